// File: rtl/nfc_io_seq.sv
// NAND flash pin sequencer: one CMD/ADDR/WDATA/RDATA strobe cycle or WAIT_RB per accepted operation.
// Optional feature: define NFC_IO_SEQ_RB_TIMEOUT_EN to bound the ready/busy wait by RB_TO cycles.
module nfc_io_seq #(
  parameter int DW     = 8,
  parameter int CE_NUM = 4,
  parameter int TW     = 4,
  parameter int RB_TO  = 65535
) (
  input  logic                                            nfc_clk,
  input  logic                                            rstb_nfc,
  input  logic [TW-1:0]                                   cfg_twp,
  input  logic [TW-1:0]                                   cfg_twh,
  input  logic                                            op_valid,
  output logic                                            op_ready,
  input  logic [2:0]                                      op_type,
  input  logic [DW-1:0]                                   op_data,
  input  logic [((CE_NUM > 1) ? $clog2(CE_NUM) : 1)-1:0]  op_ce,
  input  logic                                            op_last,
  output logic                                            rd_valid,
  output logic [DW-1:0]                                   rd_data,
  output logic                                            rb_timeout,
  output logic [CE_NUM-1:0]                               nf_ceb_o,
  output logic                                            nf_cle_o,
  output logic                                            nf_ale_o,
  output logic                                            nf_web_o,
  output logic                                            nf_reb_o,
  output logic [DW-1:0]                                   nf_dat_o,
  output logic                                            nf_io_ctrl,
  input  logic [DW-1:0]                                   nf_dat_i,
  input  logic                                            nf_rnb_i
);

  localparam int CEW = (CE_NUM > 1) ? $clog2(CE_NUM) : 1;
  localparam int CW  = (TW > 2) ? TW : 2;

  localparam logic [2:0] OP_CMD  = 3'd0;
  localparam logic [2:0] OP_ADDR = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_RD   = 3'd3;
  localparam logic [2:0] OP_WAIT = 3'd4;

  localparam logic [DW-1:0] BYTE_MASK = DW'(255);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, WB, RB} state_t;

  state_t          state_q, state_d;
  logic            ready_en;
  logic [2:0]      typ_q;
  logic [DW-1:0]   data_q;
  logic [CEW-1:0]  ce_q;
  logic            last_q;
  logic            ce_act;
  logic [CW-1:0]   cnt_q;
  logic            rnb_s1, rnb_s2;
  logic            rb_expire;
  logic            accept;
  logic            legal_op;
  logic            is_wr;
  logic            strobe_phase;

  assign op_ready = (state_q == IDLE) && ready_en;
  assign accept   = op_valid && op_ready;
  assign legal_op = (op_type <= OP_WAIT);

  always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
    if (!rstb_nfc) begin
      rnb_s1 <= 1'b1;
      rnb_s2 <= 1'b1;
    end else begin
      rnb_s1 <= nf_rnb_i;
      rnb_s2 <= rnb_s1;
    end
  end

`ifdef NFC_IO_SEQ_RB_TIMEOUT_EN
  localparam int RBW = $clog2(RB_TO + 1);
  logic [RBW-1:0] rb_cnt;
  logic           rb_to_q;

  assign rb_expire  = (rb_cnt == RBW'(RB_TO - 1));
  assign rb_timeout = rb_to_q;

  // Cycles spent in RB; cleared while in WB so each wait starts from zero.
  always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
    if (!rstb_nfc) begin
      rb_cnt  <= '0;
      rb_to_q <= 1'b0;
    end else if (state_q == WB) begin
      rb_cnt <= '0;
    end else if (state_q == RB) begin
      rb_cnt <= rb_cnt + RBW'(1);
      if (!rnb_s2 && rb_expire) rb_to_q <= 1'b1;
    end
  end
`else
  assign rb_expire  = 1'b0;
  assign rb_timeout = 1'b0;
`endif

  always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
    if (!rstb_nfc) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && legal_op) state_d = (op_type == OP_WAIT) ? WB : LOW;
      LOW:  if (cnt_q == '0) state_d = HIGH;
      HIGH: if (cnt_q == '0) state_d = IDLE;
      WB:   if (cnt_q == '0) state_d = RB;
      RB:   if (rnb_s2 || rb_expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operation latch, phase counter, CE hold and read capture.
  always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
    if (!rstb_nfc) begin
      ready_en <= 1'b0;
      typ_q    <= OP_CMD;
      data_q   <= '0;
      ce_q     <= '0;
      last_q   <= 1'b0;
      ce_act   <= 1'b0;
      cnt_q    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      ready_en <= 1'b1;
      rd_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && legal_op) begin
            typ_q  <= op_type;
            data_q <= ((op_type == OP_CMD) || (op_type == OP_ADDR)) ? (op_data & BYTE_MASK) : op_data;
            ce_q   <= op_ce;
            last_q <= op_last;
            ce_act <= 1'b1;
            cnt_q  <= (op_type == OP_WAIT) ? CW'(3) : CW'(cfg_twp);
          end
        end
        LOW: begin
          if (cnt_q == '0) begin
            cnt_q <= CW'(cfg_twh);
            if (typ_q == OP_RD) begin
              rd_data  <= nf_dat_i;
              rd_valid <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            if (last_q) ce_act <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WB: if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        RB: if ((state_d == IDLE) && last_q) ce_act <= 1'b0;
        default: ;
      endcase
    end
  end

  // Pins decode from registered state only, so reset reaches them without a clock.
  assign is_wr        = (typ_q == OP_CMD) || (typ_q == OP_ADDR) || (typ_q == OP_WR);
  assign strobe_phase = (state_q == LOW) || (state_q == HIGH);
  assign nf_web_o     = !((state_q == LOW) && is_wr);
  assign nf_reb_o     = !((state_q == LOW) && (typ_q == OP_RD));
  assign nf_cle_o     = strobe_phase && (typ_q == OP_CMD);
  assign nf_ale_o     = strobe_phase && (typ_q == OP_ADDR);
  assign nf_io_ctrl   = strobe_phase && is_wr;
  assign nf_dat_o     = nf_io_ctrl ? data_q : '0;

  always_comb begin
    nf_ceb_o = '1;
    if (ce_act) nf_ceb_o[ce_q] = 1'b0;
  end

endmodule

// File: doc/nfc_io_seq.md
NFC_IO_SEQ -- requirements
Module: nfc_io_seq

Interface
REQ-001 SHALL have parameter DW, default 8, meaning NAND data bus width (8 or 16).
REQ-002 SHALL have parameter CE_NUM, default 4, meaning number of chip enables (1..8).
REQ-003 SHALL have parameter TW, default 4, meaning width of the timing config fields.
REQ-004 SHALL have parameter RB_TO, default 65535, meaning ready/busy timeout in cycles.
REQ-005 SHALL have port nfc_clk  in  1  block clock; the block has one clock.
REQ-006 SHALL have port rstb_nfc  in  1  asynchronous active-low reset.
REQ-007 SHALL have port cfg_twp  in  TW  strobe-low cycles minus 1.
REQ-008 SHALL have port cfg_twh  in  TW  strobe-high cycles minus 1.
REQ-009 SHALL have port op_valid  in  1  operation request.
REQ-010 SHALL have port op_ready  out  1  operation accepted when op_valid&op_ready.
REQ-011 SHALL have port op_type  in  3  0=CMD, 1=ADDR, 2=WDATA, 3=RDATA, 4=WAIT_RB; 5-7 reserved.
REQ-012 SHALL have port op_data  in  DW  command/address/write data.
REQ-013 SHALL have port op_ce  in  $clog2(CE_NUM)  chip select index.
REQ-014 SHALL have port op_last  in  1  release CE after this operation.
REQ-015 SHALL have port rd_valid  out  1  one-cycle read data strobe.
REQ-016 SHALL have port rd_data  out  DW  captured read data.
REQ-017 SHALL have port rb_timeout  out  1  sticky timeout flag.
REQ-018 SHALL have NAND pins nf_ceb_o out CE_NUM, nf_cle_o out 1, nf_ale_o out 1, nf_web_o out 1, nf_reb_o out 1, nf_dat_o out DW, nf_io_ctrl out 1, nf_dat_i in DW, and nf_rnb_i in 1, as used in nfc.

Function
REQ-019 SHALL use FSM states IDLE, LOW, HIGH, WB, RB.
REQ-020 SHALL assert op_ready only in IDLE.
REQ-021 SHALL latch op_type, op_data, op_ce and op_last on acceptance, then enter LOW for CMD/ADDR/WDATA/RDATA or WB for WAIT_RB.
REQ-022 SHALL treat a reserved op_type as a one-cycle no-op: return to IDLE with no pin activity.
REQ-023 SHALL hold the strobe low for exactly cfg_twp+1 cycles in LOW, then high for cfg_twh+1 cycles in HIGH, then return to IDLE.
REQ-024 SHALL use nf_web_o as the strobe for CMD/ADDR/WDATA and nf_reb_o for RDATA; the unused strobe stays high.
REQ-025 SHALL hold nf_cle_o high (CMD) or nf_ale_o high (ADDR) throughout LOW and HIGH.
REQ-026 SHALL drive nf_io_ctrl=1 and nf_dat_o=latched data during LOW/HIGH of CMD/ADDR/WDATA, else nf_io_ctrl=0.
REQ-027 SHALL zero-extend CMD/ADDR to DW, so bits [DW-1:8] are 0.
REQ-028 SHALL sample nf_dat_i into rd_data on the last LOW cycle of RDATA and pulse rd_valid on the first HIGH cycle.
REQ-029 SHALL drive nf_ceb_o[op_ce] low from acceptance+1 and keep it low across operations until an op_last=1 operation completes; all other bits stay high.
REQ-030 SHALL force the low CE to move to the new index immediately when op_ce changes while a CE is held.
REQ-031 SHALL pass nf_rnb_i through a 2-flop synchronizer.
REQ-032 SHALL stay in WB for 4 cycles, then in RB until the synchronized rnb=1, then return to IDLE.
REQ-033 SHALL treat cfg changes during an operation as taking effect at the next LOW/HIGH entry.

Reset
REQ-034 SHALL asynchronously force on rstb_nfc=0, including mid-operation: FSM=IDLE, op_ready=0 during reset, nf_ceb_o all 1, nf_web_o=1, nf_reb_o=1, nf_cle_o=0, nf_ale_o=0, nf_io_ctrl=0, nf_dat_o=0, rd_valid=0, rd_data=0, rb_timeout=0, synchronizer=1.
REQ-035 SHALL raise op_ready on the first clock after reset release.

Configuration
REQ-036 SHALL, with macro NFC_IO_SEQ_RB_TIMEOUT_EN defined, count RB cycles and exit RB to IDLE after RB_TO cycles, setting rb_timeout sticky until reset.
REQ-037 SHALL, without NFC_IO_SEQ_RB_TIMEOUT_EN, wait in RB indefinitely with rb_timeout tied 0.

Verification
REQ-038 SHALL be verified by: cfg_twp=1, cfg_twh=0, CMD 0x70 on CE0 -> CLE high for 3 cycles, WE low for 2, nf_dat_o=0x70, nf_ceb_o=4'b1110.
REQ-039 SHALL be verified by: ADDR 0x00,0x01,0x02 with op_last=0, then RDATA op_last=1, NAND model drives 0xA5 -> rd_valid once with 0xA5; CE low continuously across all four operations, then 4'b1111.
REQ-040 SHALL be verified by: DW=16 ADDR 0x1234 -> nf_dat_o=0x0034.
REQ-041 SHALL be verified by: WAIT_RB with nf_rnb_i low for 100 cycles -> op_ready returns 2-3 cycles after rnb rises.
REQ-042 SHALL be verified by: macro defined, RB_TO=50, rnb held low -> rb_timeout=1 and IDLE after 50 RB cycles; macro undefined -> no exit.
REQ-043 SHALL be verified by: rstb_nfc asserted mid-LOW of WDATA -> all pins at reset values within the same cycle, with no further rd_valid.
